regfile_writeback: RTL and testbench

Write-side producer for the 32x64 register file. It accepts completed results from two sources:
- the ALU channel, single-cycle results;
- the load channel, variable-latency memory returns.

It arbitrates between them, buffers loads in a small FIFO, and drives the register file's single write port (rd, WriteData, RegWrite) from registered outputs. Writes to x0 are absorbed here so the register file never sees them.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/regfile_writeback.sv | 107 ++++++++++
 tb/tb_regfile_writeback.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core types: architectural widths, the x0 index, and the write-back request
// carried by both result channels and the load FIFO.
package rv_core_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage : rv_core_pkg

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests with wrapping pointers and an occupancy count.
// The head entry is presented combinationally on pop_data whenever the FIFO is non-empty.
module wb_fifo
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  wb_req_t                    push_data,
   input  logic                       pop,
   output wb_req_t                    pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_req_t              mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;

   // NOTE: storage has no reset; validity is tracked entirely by count_q, so the
   // array can map onto plain flops or a RAM without a reset network.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // NOTE: sequential state is always updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule : wb_fifo

// File: rtl/regfile_writeback.sv
// Write-side producer for the register file: arbitrates ALU results against buffered
// loads with bounded load starvation, and drives a registered write port that never writes x0.
module regfile_writeback
   import rv_core_pkg::*;
#(
   parameter int XLEN       = rv_core_pkg::XLEN,
   parameter int ADDR_W     = rv_core_pkg::REG_ADDR_W,
   parameter int LD_DEPTH   = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [ADDR_W-1:0]             alu_rd,
   input  logic [XLEN-1:0]               alu_data,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [ADDR_W-1:0]             ld_rd,
   input  logic [XLEN-1:0]               ld_data,
   output logic                          wb_we,
   output logic [ADDR_W-1:0]             wb_rd,
   output logic [XLEN-1:0]               wb_data,
   output logic [$clog2(LD_DEPTH+1)-1:0] ld_pending
);

   localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   wb_req_t             ld_head;
   wb_req_t             ld_push_req;
   logic                fifo_full;
   logic                fifo_empty;
   logic                sel_ld;
   logic                ld_push;

   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                wb_we_q, wb_we_d;
   logic [ADDR_W-1:0]   wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]     wb_data_q, wb_data_d;

   assign ld_push_req = '{rd: ld_rd, data: ld_data};

   wb_fifo #(
      .DEPTH(LD_DEPTH)
   ) u_ld_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ld_push),
      .push_data(ld_push_req),
      .pop      (sel_ld),
      .pop_data (ld_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (ld_pending)
   );

   // A full FIFO always wins, which is what lets a new load enter in the same cycle.
   assign sel_ld    = !fifo_empty &&
                      (!alu_valid || fifo_full || (starve_q == STARVE_W'(STARVE_MAX)));
   assign alu_ready = !sel_ld;
   assign ld_ready  = !fifo_full || sel_ld;
   assign ld_push   = ld_valid && ld_ready;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      wb_we_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      starve_d  = starve_q;

      if (sel_ld) begin
         wb_we_d   = (ld_head.rd != REG_X0);
         wb_rd_d   = ld_head.rd;
         wb_data_d = ld_head.data;
      end else if (alu_valid) begin
         wb_we_d   = (alu_rd != REG_X0);
         wb_rd_d   = alu_rd;
         wb_data_d = alu_data;
      end

      // Counts ALU grants that bypass a waiting load; saturates at the limit.
      if (fifo_empty || sel_ld) begin
         starve_d = '0;
      end else if (alu_valid && (starve_q != STARVE_W'(STARVE_MAX))) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         starve_q  <= '0;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         starve_q  <= starve_d;
      end
   end

   assign wb_we   = wb_we_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;

endmodule : regfile_writeback

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU and load paths, starvation limit,
// full-FIFO push/pop, x0 suppression and reset in the middle of buffered traffic.
module tb_regfile_writeback;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [63:0] ld_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [2:0]  ld_pending;

   int checks   = 0;
   int failures = 0;

   regfile_writeback dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .ld_pending(ld_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench did not terminate");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; sampling and driving happen 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      ld_valid  = 1'b0;
      ld_rd     = '0;
      ld_data   = '0;

      // Asynchronous reset asserted between edges.
      #3 rst_n = 1'b0;
      #1;
      check("rst_wb_we",    64'(wb_we),      64'd0);
      check("rst_wb_rd",    64'(wb_rd),      64'd0);
      check("rst_wb_data",  wb_data,         64'd0);
      check("rst_pending",  64'(ld_pending), 64'd0);
      check("rst_alu_rdy",  64'(alu_ready),  64'd1);
      check("rst_ld_rdy",   64'(ld_ready),   64'd1);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Single ALU write.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF_0000_0001;
      #1 check("alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      check("alu_we",   64'(wb_we), 64'd1);
      check("alu_rd",   64'(wb_rd), 64'd5);
      check("alu_data", wb_data,    64'hDEAD_BEEF_0000_0001);
      tick();
      check("alu_we_off",  64'(wb_we), 64'd0);
      check("alu_rd_hold", 64'(wb_rd), 64'd5);

      // Single load, ALU idle: two edges through the FIFO.
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h1234;
      #1 check("ld_ready", 64'(ld_ready), 64'd1);
      tick();
      ld_valid = 1'b0;
      check("ld_pend1",  64'(ld_pending), 64'd1);
      check("ld_we_lat", 64'(wb_we),      64'd0);
      tick();
      check("ld_we",    64'(wb_we),      64'd1);
      check("ld_rd",    64'(wb_rd),      64'd7);
      check("ld_data",  wb_data,         64'h1234);
      check("ld_pend0", 64'(ld_pending), 64'd0);
      tick();
      check("ld_we_off", 64'(wb_we), 64'd0);

      // Starvation: continuous ALU traffic, one load (rd 9) arriving with rd 1.
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'd101;
      ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 64'h99;
      tick();
      ld_valid = 1'b0;
      check("stv_rd1", 64'(wb_rd), 64'd1);
      for (int i = 2; i <= 4; i++) begin
         alu_rd = 5'(i); alu_data = 64'(100 + i);
         #1 check("stv_alu_rdy", 64'(alu_ready), 64'd1);
         tick();
         check("stv_alu_rd", 64'(wb_rd), 64'(i));
         check("stv_alu_we", 64'(wb_we), 64'd1);
      end
      alu_rd = 5'd5; alu_data = 64'd105;
      #1 check("stv_alu_blocked", 64'(alu_ready), 64'd0);
      tick();
      check("stv_ld_rd",   64'(wb_rd),   64'd9);
      check("stv_ld_data", wb_data,      64'h99);
      check("stv_ld_we",   64'(wb_we),   64'd1);
      check("stv_resume",  64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      check("stv_alu5", 64'(wb_rd), 64'd5);
      tick();

      // Fill the FIFO behind a busy ALU, then push a fifth load during the pop.
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'd200;
      ld_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ld_rd = 5'(11 + i); ld_data = 64'(300 + i);
         tick();
         check("full_alu_rd", 64'(wb_rd), 64'd20);
      end
      ld_rd = 5'd15; ld_data = 64'd304;
      check("full_pend4",   64'(ld_pending), 64'd4);
      #1 check("full_alu_rdy", 64'(alu_ready),  64'd0);
      check("full_ld_rdy",  64'(ld_ready),   64'd1);
      tick();
      ld_valid = 1'b0; alu_valid = 1'b0;
      check("full_pushpop_pend", 64'(ld_pending), 64'd4);
      check("full_order_rd",     64'(wb_rd),      64'd11);
      check("full_order_data",   wb_data,         64'd300);
      for (int i = 1; i < 5; i++) begin
         tick();
         check("full_order_rd",   64'(wb_rd), 64'(11 + i));
         check("full_order_data", wb_data,    64'(300 + i));
         check("full_order_we",   64'(wb_we), 64'd1);
      end
      check("full_drained", 64'(ld_pending), 64'd0);
      tick();

      // x0 on both channels: handshake completes, no write enable.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
      #1 check("x0_alu_rdy", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      check("x0_alu_we",   64'(wb_we), 64'd0);
      check("x0_alu_data", wb_data,    64'hFFFF);
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h55;
      tick();
      ld_valid = 1'b0;
      check("x0_ld_pend", 64'(ld_pending), 64'd1);
      tick();
      check("x0_ld_we",    64'(wb_we),      64'd0);
      check("x0_ld_pend0", 64'(ld_pending), 64'd0);
      tick();

      // Buffer three loads behind the ALU, then reset mid-operation.
      alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'd400;
      ld_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_rd = 5'(24 + i); ld_data = 64'(500 + i);
         tick();
      end
      check("mid_pend3", 64'(ld_pending), 64'd3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_pend", 64'(ld_pending), 64'd0);
      check("mid_rst_we",   64'(wb_we),      64'd0);
      check("mid_rst_rd",   64'(wb_rd),      64'd0);
      check("mid_rst_data", wb_data,         64'd0);
      alu_valid = 1'b0; ld_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_we",   64'(wb_we),      64'd0);
         check("post_rst_pend", 64'(ld_pending), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_writeback
